// File: rtl/jt51_mix_pkg.sv
// Shared constants and types for the jt51 output mixer.
package jt51_mix_pkg;

  localparam int WIDTH_IN_DEF  = 14;
  localparam int WIDTH_OUT_DEF = 16;
  localparam int SLOTS_DEF     = 32;

  // 32 slots x 14-bit signed operators fit exactly in 19 bits signed.
  localparam int ACC_W   = 19;
  localparam int OUT_MAX = 32'sd32767;
  localparam int OUT_MIN = -32'sd32768;
  localparam int CNT_W   = $clog2(SLOTS_DEF);

  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/jt51_mix_sat.sv
// Combinational saturator: clamps a frame accumulator to the sample range.
// With JT51_MIX_CLIP_EN defined, ovf reports that clamping engaged;
// otherwise the detect output is held at 0.
module jt51_mix_sat
  import jt51_mix_pkg::*;
#(
  parameter int WIDTH_OUT = WIDTH_OUT_DEF
) (
  input  acc_t                 acc_in,
  output logic [WIDTH_OUT-1:0] sat_out,
  output logic                 ovf
);

  localparam acc_t                 ACC_HI = acc_t'(OUT_MAX);
  localparam acc_t                 ACC_LO = acc_t'(OUT_MIN);
  localparam logic [WIDTH_OUT-1:0] OUT_HI = WIDTH_OUT'(OUT_MAX);
  localparam logic [WIDTH_OUT-1:0] OUT_LO = WIDTH_OUT'(OUT_MIN);

  logic over_hi;
  logic over_lo;

  // Range comparison on the signed accumulator and clamp selection.
  always_comb begin
    over_hi = (acc_in > ACC_HI);
    over_lo = (acc_in < ACC_LO);
    if (over_hi) begin
      sat_out = OUT_HI;
    end else if (over_lo) begin
      sat_out = OUT_LO;
    end else begin
      sat_out = acc_in[WIDTH_OUT-1:0];
    end
  end

`ifdef JT51_MIX_CLIP_EN
  assign ovf = over_hi | over_lo;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/jt51_mix_acc.sv
// jt51 output mixer: accumulates carrier operators of every slot into
// left/right sums and latches saturated samples at each frame boundary.
// Optional build macro JT51_MIX_CLIP_EN enables the clip flag; without it
// clip stays 0.
module jt51_mix_acc
  import jt51_mix_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_IN_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int SLOTS     = SLOTS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 zero,
  input  logic [WIDTH_IN-1:0]  op_out,
  input  logic                 is_carrier,
  input  logic [1:0]           rl,
  output logic [WIDTH_OUT-1:0] left,
  output logic [WIDTH_OUT-1:0] right,
  output logic                 sample,
  output logic                 desync,
  output logic                 clip
);

  localparam int                CNT_BITS = $clog2(SLOTS);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 locked_q, locked_d;
  acc_t                 acc_l_q, acc_l_d;
  acc_t                 acc_r_q, acc_r_d;
  logic [WIDTH_OUT-1:0] left_q, left_d;
  logic [WIDTH_OUT-1:0] right_q, right_d;
  logic                 sample_q, sample_d;
  logic                 desync_q, desync_d;
  logic                 clip_q, clip_d;

  acc_t                 op_ext;
  acc_t                 add_l;
  acc_t                 add_r;
  logic [WIDTH_OUT-1:0] sat_l;
  logic [WIDTH_OUT-1:0] sat_r;
  logic                 ovf_l;
  logic                 ovf_r;

  assign op_ext = acc_t'($signed(op_out));

  // Per-channel contribution: carrier operators routed to that channel only.
  always_comb begin
    if (is_carrier && rl[0]) begin
      add_l = op_ext;
    end else begin
      add_l = '0;
    end
    if (is_carrier && rl[1]) begin
      add_r = op_ext;
    end else begin
      add_r = '0;
    end
  end

  jt51_mix_sat #(.WIDTH_OUT(WIDTH_OUT)) u_sat_l (
    .acc_in (acc_l_q),
    .sat_out(sat_l),
    .ovf    (ovf_l)
  );

  jt51_mix_sat #(.WIDTH_OUT(WIDTH_OUT)) u_sat_r (
    .acc_in (acc_r_q),
    .sat_out(sat_r),
    .ovf    (ovf_r)
  );

  // Next-state: slot counting, frame lock/alignment check, accumulate, latch.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    left_d   = left_q;
    right_d  = right_q;
    sample_d = 1'b0;
    desync_d = desync_q;
    clip_d   = clip_q;
    if (cen) begin
      // A zero off slot 0, or slot 0 without zero, is an alignment error.
      if (locked_q && (zero != (cnt_q == CNT_ZERO))) begin
        desync_d = 1'b1;
      end else begin
        desync_d = desync_q;
      end
      if (zero) begin
        locked_d = 1'b1;
        cnt_d    = CNT_ONE;
        acc_l_d  = add_l;
        acc_r_d  = add_r;
        // The very first zero only establishes lock; nothing to publish yet.
        if (locked_q) begin
          left_d   = sat_l;
          right_d  = sat_r;
          sample_d = 1'b1;
          clip_d   = ovf_l | ovf_r;
        end else begin
          sample_d = 1'b0;
        end
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
        acc_l_d = acc_l_q + add_l;
        acc_r_d = acc_r_q + add_r;
      end
    end else begin
      sample_d = 1'b0;
    end
  end

  // State registers, asynchronously cleared so reset drops outputs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= CNT_ZERO;
      locked_q <= 1'b0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      desync_q <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      sample_q <= sample_d;
      desync_q <= desync_d;
      clip_q   <= clip_d;
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;
  assign desync = desync_q;
  assign clip   = clip_q;

endmodule

// File: tb/tb_jt51_mix_acc.sv
// Self-checking bench for jt51_mix_acc with a frame-level reference model.
module tb_jt51_mix_acc;

`ifdef JT51_MIX_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        zero = 1'b0;
  logic [13:0] op_out = '0;
  logic        is_carrier = 1'b0;
  logic [1:0]  rl = 2'b00;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample;
  logic        desync;
  logic        clip;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers, no wrap).
  int m_l, m_r, m_cnt;
  bit m_locked, m_desync;
  int e_left, e_right;
  bit e_sample, e_clip;

  jt51_mix_acc dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
    .op_out    (op_out),
    .is_carrier(is_carrier),
    .rl        (rl),
    .left      (left),
    .right     (right),
    .sample    (sample),
    .desync    (desync),
    .clip      (clip)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rand_op();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  task automatic model_reset();
    m_l = 0; m_r = 0; m_cnt = 0;
    m_locked = 1'b0; m_desync = 1'b0;
    e_left = 0; e_right = 0; e_sample = 1'b0; e_clip = 1'b0;
  endtask

  // One clock with the given inputs; model updated, all outputs compared.
  task automatic step(input bit c, input bit z, input int op, input bit car,
                      input bit [1:0] r, input string tag);
    int cl, cr;
    @(negedge clk);
    cen = c; zero = z; op_out = op[13:0]; is_carrier = car; rl = r;
    e_sample = 1'b0;
    if (c) begin
      cl = (car && r[0]) ? op : 0;
      cr = (car && r[1]) ? op : 0;
      if (m_locked && (z != (m_cnt == 0))) m_desync = 1'b1;
      if (z) begin
        if (m_locked) begin
          e_left = sat16(m_l);
          e_right = sat16(m_r);
          e_sample = 1'b1;
          e_clip = CLIP_EN && ((e_left != m_l) || (e_right != m_r));
        end
        m_locked = 1'b1; m_cnt = 1; m_l = cl; m_r = cr;
      end else begin
        m_cnt = (m_cnt + 1) % 32;
        m_l += cl; m_r += cr;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sample !== e_sample) begin
      failures++; $display("FAIL %s sample: got %0b want %0b", tag, sample, e_sample);
    end
    checks++;
    if (left !== e_left[15:0]) begin
      failures++; $display("FAIL %s left: got %0d want %0d", tag, $signed(left), e_left);
    end
    checks++;
    if (right !== e_right[15:0]) begin
      failures++; $display("FAIL %s right: got %0d want %0d", tag, $signed(right), e_right);
    end
    checks++;
    if (desync !== m_desync) begin
      failures++; $display("FAIL %s desync: got %0b want %0b", tag, desync, m_desync);
    end
    checks++;
    if (clip !== e_clip) begin
      failures++; $display("FAIL %s clip: got %0b want %0b", tag, clip, e_clip);
    end
  endtask

  // Slots first..first+n-1 without zero; carrier off on odd slots if odd_off.
  task automatic frame_rest(input int op, input bit odd_off, input bit [1:0] r,
                            input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(1'b1, 1'b0, op, !(odd_off && (i % 2 == 1)), r, tag);
    end
  endtask

  // Zero cen that closes a frame (and starts the next one); fixed-value check.
  task automatic close(input int op, input bit car, input bit [1:0] r,
                       input int want_l, input int want_r, input string tag);
    step(1'b1, 1'b1, op, car, r, tag);
    checks++;
    if (left !== want_l[15:0] || right !== want_r[15:0] || sample !== 1'b1) begin
      failures++;
      $display("FAIL %s latch: got l=%0d r=%0d s=%0b want l=%0d r=%0d s=1",
               tag, $signed(left), $signed(right), sample, want_l, want_r);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cen = 1'b0; zero = 1'b0;
    #1;
    model_reset();
    checks++;
    if (left !== 16'd0 || right !== 16'd0 || sample !== 1'b0 || desync !== 1'b0 || clip !== 1'b0) begin
      failures++;
      $display("FAIL reset: got l=%0d r=%0d s=%0b d=%0b c=%0b want all 0",
               $signed(left), $signed(right), sample, desync, clip);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sums();
    step(1'b1, 1'b1, 100, 1'b1, 2'b11, "lock");
    frame_rest(100, 1'b0, 2'b11, 31, "basic");
    close(8191, 1'b1, 2'b11, 3200, 3200, "basic");
    step(1'b0, 1'b0, 0, 1'b0, 2'b00, "basic_gap");
    frame_rest(8191, 1'b0, 2'b11, 31, "satpos");
    close(-8192, 1'b1, 2'b11, 32767, 32767, "satpos");
    checks++;
    if (clip !== CLIP_EN) begin
      failures++; $display("FAIL satpos clip: got %0b want %0b", clip, CLIP_EN);
    end
    frame_rest(-8192, 1'b0, 2'b11, 31, "satneg");
    close(100, 1'b1, 2'b01, -32768, -32768, "satneg");
    frame_rest(100, 1'b1, 2'b01, 31, "route");
    close(100, 1'b1, 2'b11, 1600, 0, "route");
    checks++;
    if (desync !== 1'b0) begin
      failures++; $display("FAIL aligned desync: got %0b want 0", desync);
    end
  endtask

  task automatic test_early_zero();
    frame_rest(100, 1'b0, 2'b11, 19, "early");
    close(100, 1'b1, 2'b11, 2000, 2000, "early");
    checks++;
    if (desync !== 1'b1) begin
      failures++; $display("FAIL early desync: got %0b want 1", desync);
    end
    frame_rest(100, 1'b0, 2'b11, 31, "after_early");
    close(0, 1'b1, 2'b11, 3200, 3200, "after_early");
    test_reset();
    checks++;
    if (desync !== 1'b0) begin
      failures++; $display("FAIL rst clears desync: got %0b want 0", desync);
    end
  endtask

  task automatic test_missing_zero();
    step(1'b1, 1'b1, 100, 1'b1, 2'b11, "miss_lock");
    frame_rest(100, 1'b0, 2'b11, 31, "miss_pre");
    close(100, 1'b1, 2'b11, 3200, 3200, "miss_pre");
    frame_rest(100, 1'b0, 2'b11, 63, "miss");
    close(0, 1'b1, 2'b11, 6400, 6400, "miss");
    test_reset();
  endtask

  task automatic test_reset_midframe();
    int sum;
    step(1'b1, 1'b1, 50, 1'b1, 2'b11, "mid_lock");
    frame_rest(50, 1'b0, 2'b11, 31, "mid_pre");
    close(50, 1'b1, 2'b11, 1600, 1600, "mid_pre");
    frame_rest(50, 1'b0, 2'b11, 14, "mid_part");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (left !== 16'd0 || right !== 16'd0 || sample !== 1'b0) begin
      failures++;
      $display("FAIL async reset: got l=%0d r=%0d s=%0b want 0 0 0", $signed(left), $signed(right), sample);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    sum = rand_op();
    step(1'b1, 1'b1, sum, 1'b1, 2'b11, "post_rst_lock");
    for (int i = 1; i < 32; i++) begin
      int op;
      op = rand_op();
      sum += op;
      step(1'b1, 1'b0, op, 1'b1, 2'b11, "post_rst");
    end
    close(0, 1'b1, 2'b11, sat16(sum), sat16(sum), "post_rst");
  endtask

  task automatic test_random();
    test_reset();
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < 32; s++) begin
        while ($urandom_range(3) == 0) begin
          step(1'b0, 1'($urandom_range(1)), rand_op(), 1'b1, 2'b11, "rand_idle");
        end
        step(1'b1, s == 0, rand_op(), 1'($urandom_range(1)), 2'($urandom_range(3)), "rand");
      end
    end
    step(1'b1, 1'b1, 0, 1'b0, 2'b00, "rand_end");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sums();
    test_early_zero();
    test_missing_zero();
    test_reset_midframe();
    test_random();
    @(negedge clk);
    cen = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
